// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous input, filters glitches shorter than DEBOUNCE_CYCLES
// enabled cycles, and produces the qualified level plus one-cycle rise/fall pulses.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_WIDTH       = 8,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_raw,
    input  logic en,
    output logic q,
    output logic qb,
    output logic q_rise,
    output logic q_fall,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path can infer a latch.
        sync_d = {sync_q[SYNC_STAGES-2:0], d_raw};
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;

        if (en) begin
            if (sync_out == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                // Mismatch held long enough: accept the new level and pulse once.
                lvl_d  = sync_out;
                cnt_d  = '0;
                rise_d = sync_out;
                fall_d = ~sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            cnt_q  <= '0;
            lvl_q  <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q      = lvl_q;
    assign qb     = ~lvl_q;
    assign q_rise = rise_q;
    assign q_fall = fall_q;
    assign busy   = sync_out ^ lvl_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: table of per-edge vectors plus hand-written reset sequences,
// with expected outputs queued at drive time and popped when sampled after the edge.
module tb_debounce_sync;

    logic clk;
    logic reset0, d_raw0, en0, q0, qb0, rise0, fall0, busy0;
    logic reset1, d_raw1, en1, q1, qb1, rise1, fall1, busy1;

    // Expected outputs packed as {q, qb, q_rise, q_fall, busy}.
    typedef struct {
        logic       rst;
        logic       d;
        logic       en;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] sb_q[$];
    int         n_checks;
    int         n_fail;

    debounce_sync #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(8), .RESET_VAL(1'b0)
    ) u_dut0 (
        .clk(clk), .reset(reset0), .d_raw(d_raw0), .en(en0),
        .q(q0), .qb(qb0), .q_rise(rise0), .q_fall(fall0), .busy(busy0)
    );

    debounce_sync #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(8), .RESET_VAL(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(reset1), .d_raw(d_raw1), .en(en1),
        .q(q1), .qb(qb1), .q_rise(rise1), .q_fall(fall1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] outs(logic eq, logic er, logic ef, logic eb);
        return {eq, ~eq, er, ef, eb};
    endfunction

    function automatic logic [4:0] dut_outs(int inst);
        if (inst == 0) return {q0, qb0, rise0, fall0, busy0};
        return {q1, qb1, rise1, fall1, busy1};
    endfunction

    task automatic check(string name, logic [4:0] act, logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: q/qb/rise/fall/busy got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(logic rst, logic d, logic en, logic eq, logic er, logic ef, logic eb);
        vec_t v;
        v.rst = rst;
        v.d   = d;
        v.en  = en;
        v.exp = outs(eq, er, ef, eb);
        vecs.push_back(v);
    endtask

    // Drive one instance on the falling edge, sample it 1 time unit after the rising edge.
    task automatic step(int inst, logic rst, logic d, logic en, logic [4:0] exp, string name);
        @(negedge clk);
        if (inst == 0) begin
            reset0 = rst; d_raw0 = d; en0 = en;
        end else begin
            reset1 = rst; d_raw1 = d; en1 = en;
        end
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        check(name, dut_outs(inst), sb_q.pop_front());
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset0 = 1'b1; d_raw0 = 1'bx; en0 = 1'b1;
        reset1 = 1'b1; d_raw1 = 1'b0; en1 = 1'b1;
        #1;
        check("reset_val0", dut_outs(0), outs(1'b0, 1'b0, 1'b0, 1'b0));
        check("reset_val1", dut_outs(1), outs(1'b1, 1'b0, 1'b0, 1'b0));

        // Reset with unknown input, then idle low: nothing may move.
        add(1, 1'bx, 1, 0, 0, 0, 0);
        add(1, 1'bx, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 0, 0, 0);

        // Clean 0->1: sync_out after E1, q and rise pulse after E5.
        add(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0);

        // 1->0 with en on every 3rd edge (E2, E5, E8, E11): q falls on E11.
        for (int i = 0; i < 14; i++) begin
            logic en_i;
            en_i = ((i % 3) == 2);
            if (i == 0)       add(0, 0, en_i, 1, 0, 0, 0);
            else if (i <= 10) add(0, 0, en_i, 1, 0, 0, 1);
            else if (i == 11) add(0, 0, en_i, 0, 0, 1, 0);
            else              add(0, 0, en_i, 0, 0, 0, 0);
        end

        // Two-cycle glitch high: busy for two cycles, q and pulses untouched.
        add(0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(0, vecs[i].rst, vecs[i].d, vecs[i].en, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // New rise right after the glitch: a leftover count would accept early (by E3).
        step(0, 0, 1, 1, outs(0, 0, 0, 0), "midrst_e0");
        for (int i = 1; i <= 3; i++) step(0, 0, 1, 1, outs(0, 0, 0, 1), $sformatf("midrst_e%0d", i));
        // cnt is 2 here; reset between edges must clear the synchronizer at once.
        #1 reset0 = 1'b1;
        #1 check("async_rst_qual", dut_outs(0), outs(0, 0, 0, 0));
        step(0, 1, 1, 1, outs(0, 0, 0, 0), "rst_hold");
        step(0, 0, 1, 1, outs(0, 0, 0, 0), "rel_e0");
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 1, outs(0, 0, 0, 1), $sformatf("rel_e%0d", i));
        step(0, 0, 1, 1, outs(1, 1, 0, 0), "rel_e5");
        // Reset during the rise pulse: q and q_rise drop without a clock edge.
        #1 reset0 = 1'b1;
        #1 check("async_rst_pulse", dut_outs(0), outs(0, 0, 0, 0));
        step(0, 1, 0, 1, outs(0, 0, 0, 0), "rst_hold2");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, outs(0, 0, 0, 0), $sformatf("idle%0d", i));

        // RESET_VAL=1 instance: high input after release is already qualified.
        check("rv1_held", dut_outs(1), outs(1, 0, 0, 0));
        for (int i = 0; i < 6; i++) step(1, 0, 1, 1, outs(1, 0, 0, 0), $sformatf("rv1_hi%0d", i));
        step(1, 0, 0, 1, outs(1, 0, 0, 0), "rv1_fall_e0");
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 1, outs(1, 0, 0, 1), $sformatf("rv1_fall_e%0d", i));
        step(1, 0, 0, 1, outs(0, 0, 1, 0), "rv1_fall_e5");
        step(1, 0, 0, 1, outs(0, 0, 0, 0), "rv1_fall_e6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
